i2c_bit_phy: RTL and testbench

Bit-level I2C bus engine sitting directly downstream of the low-level I2C controller FSM (`i2c_ctlr_ll`). It accepts one bus primitive at a time (START, repeated START, STOP, write bit, read bit) over a valid/ready handshake. It generates SCL timing from a programmable quarter-period divider and drives open-drain SCL/SDA enables. It samples SDA, honours target clock stretching, detects multi-controller arbitration loss and tracks bus-busy state.

---
 rtl/i2c_bit_phy_pkg.sv | 68 ++++++
 rtl/i2c_sync2.sv | 34 +++
 rtl/i2c_bit_phy.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_bit_phy.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_bit_phy_pkg.sv
// Shared definitions for the I2C bit engine: op codes, quarter encodings,
// FSM states and the per-quarter line-level table.
package i2c_bit_phy_pkg;

    localparam logic [2:0] I2C_OP_START   = 3'd0;
    localparam logic [2:0] I2C_OP_RESTART = 3'd1;
    localparam logic [2:0] I2C_OP_STOP    = 3'd2;
    localparam logic [2:0] I2C_OP_WRITE   = 3'd3;
    localparam logic [2:0] I2C_OP_READ    = 3'd4;

    localparam logic [1:0] I2C_Q0 = 2'd0;
    localparam logic [1:0] I2C_Q1 = 2'd1;
    localparam logic [1:0] I2C_Q2 = 2'd2;
    localparam logic [1:0] I2C_Q3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Open-drain enables: 1 pulls the line low, 0 releases it.
    typedef struct packed {
        logic scl;
        logic sda;
    } oe_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= I2C_OP_READ;
    endfunction

    // Line levels for one quarter of a bus primitive.
    function automatic oe_t quarter_oe(input logic [2:0] op,
                                       input logic [1:0] qtr,
                                       input logic       wbit);
        oe_t r;
        r.scl = 1'b0;
        r.sda = 1'b0;
        case (op)
            I2C_OP_START: begin
                r.scl = (qtr == I2C_Q2) || (qtr == I2C_Q3);
                r.sda = (qtr != I2C_Q0);
            end
            I2C_OP_RESTART: begin
                r.scl = (qtr == I2C_Q0) || (qtr == I2C_Q3);
                r.sda = (qtr == I2C_Q2) || (qtr == I2C_Q3);
            end
            I2C_OP_STOP: begin
                r.scl = (qtr == I2C_Q0);
                r.sda = (qtr == I2C_Q0) || (qtr == I2C_Q1);
            end
            I2C_OP_WRITE: begin
                r.scl = (qtr == I2C_Q0) || (qtr == I2C_Q3);
                r.sda = ~wbit;
            end
            I2C_OP_READ: begin
                r.scl = (qtr == I2C_Q0) || (qtr == I2C_Q3);
                r.sda = 1'b0;
            end
            default: begin
                r.scl = 1'b0;
                r.sda = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous pad input, with a selectable
// reset value so an idle (released) bus line reads high out of reset.
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-value selection for the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_bit_phy.sv
// Bit-level I2C bus engine: executes one START/RESTART/STOP/WRITE/READ
// primitive per command as four timed quarters, honours clock stretching,
// detects arbitration loss and tracks bus-busy from observed conditions.
module i2c_bit_phy
    import i2c_bit_phy_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] cfg_div,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic                  cmd_bit,
    output logic                  rsp_valid,
    output logic                  rsp_bit,
    output logic                  rsp_arb_lost,
    output logic                  bus_busy,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe,
    output logic                  sda_oe
);

    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic scl_s, sda_s;

    state_t                state_q, state_d;
    logic [1:0]            quarter_q, quarter_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [2:0]            op_q, op_d;
    logic                  bit_q, bit_d;
    logic                  scl_oe_q, scl_oe_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  res_bit_q, res_bit_d;
    logic                  res_arb_q, res_arb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_bit_q, rsp_bit_d;
    logic                  rsp_arb_q, rsp_arb_d;
    logic                  owner_q, owner_d;
    logic                  busy_q, busy_d;
    logic                  sda_prev_q, sda_prev_d;

    oe_t  cur_oe, nxt_oe, acc_oe;
    logic stall, lost;

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_scl (.clk(clk), .rst(rst), .d(scl_i), .q(scl_s));
    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_sda (.clk(clk), .rst(rst), .d(sda_i), .q(sda_s));

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_bit      = rsp_bit_q;
    assign rsp_arb_lost = rsp_arb_q;
    assign bus_busy     = busy_q;
    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;

    // START/STOP condition detection on the synchronized bus (any controller).
    always_comb begin
        busy_d     = busy_q;
        sda_prev_d = sda_s;
        if (scl_s && sda_prev_q && !sda_s) begin
            busy_d = 1'b1;
        end else if (scl_s && !sda_prev_q && sda_s) begin
            busy_d = 1'b0;
        end
    end

    // Command sequencing. Line enables are computed from the next quarter so
    // they change on the same edge the quarter begins; this keeps the
    // stretching wait down to the synchronizer delay under loopback.
    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        op_d        = op_q;
        bit_d       = bit_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        res_bit_d   = res_bit_q;
        res_arb_d   = res_arb_q;
        owner_d     = owner_q;
        rsp_valid_d = 1'b0;
        rsp_bit_d   = 1'b0;
        rsp_arb_d   = 1'b0;
        lost        = 1'b0;
        cur_oe      = quarter_oe(op_q, quarter_q, bit_q);
        nxt_oe      = quarter_oe(op_q, quarter_q + 2'd1, bit_q);
        acc_oe      = quarter_oe(cmd_op, I2C_Q0, cmd_bit);
        // A quarter with SCL released waits until the line is actually high.
        stall       = !cur_oe.scl && !scl_s;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    div_d     = cfg_div;
                    op_d      = cmd_op;
                    bit_d     = cmd_bit;
                    quarter_d = I2C_Q0;
                    cnt_d     = '0;
                    res_bit_d = 1'b0;
                    res_arb_d = 1'b0;
                    if (!op_legal(cmd_op)) begin
                        state_d = ST_RESP;
                    end else if (cmd_op == I2C_OP_START && busy_q && !owner_q) begin
                        // Someone else holds the bus: refuse without touching it.
                        res_arb_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d  = ST_CMD;
                        scl_oe_d = acc_oe.scl;
                        sda_oe_d = acc_oe.sda;
                    end
                end
            end
            ST_CMD: begin
                if (!stall) begin
                    if (cnt_q == div_q) begin
                        if (quarter_q == I2C_Q0 && op_q == I2C_OP_START && !sda_s) begin
                            lost = 1'b1;
                        end
                        if (quarter_q == I2C_Q2 &&
                            (op_q == I2C_OP_WRITE || op_q == I2C_OP_READ)) begin
                            res_bit_d = sda_s;
                            if (op_q == I2C_OP_WRITE && bit_q && !sda_s) begin
                                lost = 1'b1;
                            end
                        end
                        if (lost) begin
                            scl_oe_d  = 1'b0;
                            sda_oe_d  = 1'b0;
                            owner_d   = 1'b0;
                            res_arb_d = 1'b1;
                            state_d   = ST_RESP;
                        end else if (quarter_q == I2C_Q3) begin
                            state_d = ST_RESP;
                            if (op_q == I2C_OP_START) begin
                                owner_d = 1'b1;
                            end
                            if (op_q == I2C_OP_STOP) begin
                                owner_d = 1'b0;
                            end
                        end else begin
                            quarter_d = quarter_q + 2'd1;
                            cnt_d     = '0;
                            scl_oe_d  = nxt_oe.scl;
                            sda_oe_d  = nxt_oe.sda;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_bit_d   = res_bit_q;
                rsp_arb_d   = res_arb_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output state; reset releases both lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            res_bit_q   <= 1'b0;
            res_arb_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_arb_q   <= 1'b0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            sda_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            res_bit_q   <= res_bit_d;
            res_arb_q   <= res_arb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_arb_q   <= rsp_arb_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            sda_prev_q  <= sda_prev_d;
        end
    end

    // Per-command data, loaded at accept and only read while a command runs.
    always_ff @(posedge clk) begin
        quarter_q <= quarter_d;
        cnt_q     <= cnt_d;
        div_q     <= div_d;
        op_q      <= op_d;
        bit_q     <= bit_d;
    end

endmodule

// File: tb/tb_i2c_bit_phy.sv
// Directed bench for i2c_bit_phy on a wired-AND loopback bus with an
// external clock-stretcher and an SDA competitor.
module tb_i2c_bit_phy;

    localparam logic [2:0] OP_START   = 3'd0;
    localparam logic [2:0] OP_RESTART = 3'd1;
    localparam logic [2:0] OP_STOP    = 3'd2;
    localparam logic [2:0] OP_WRITE   = 3'd3;
    localparam logic [2:0] OP_READ    = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_div = 16'd3;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic        cmd_bit = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_bit, rsp_arb_lost, bus_busy;
    logic        scl_i, sda_i, scl_oe, sda_oe;
    logic        ext_scl = 1'b0;
    logic        comp_sda = 1'b0;

    int total = 0;
    int bad = 0;
    int lat;
    logic rb, ra, rr;

    assign scl_i = ~(scl_oe | ext_scl);
    assign sda_i = ~(sda_oe | comp_sda);

    always #5 clk = ~clk;

    i2c_bit_phy #(.PRESCALE_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_div(cfg_div),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
        .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_arb_lost(rsp_arb_lost),
        .bus_busy(bus_busy), .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // Present one command, scramble cfg_div after accept, and measure the
    // number of edges from accept to the response pulse.
    task automatic issue(input logic [2:0] op, input logic b, input logic [15:0] div,
                         output int l, output logic rbit, output logic rarb, output logic rdy);
        int g;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        cfg_div = div; cmd_op = op; cmd_bit = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cfg_div = 16'h00BE;
        l = 0;
        while (!rsp_valid && l < 3000) begin
            @(posedge clk); #1; l++;
        end
        rbit = rsp_bit; rarb = rsp_arb_lost; rdy = cmd_ready;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe got=%b want=00", {scl_oe, sda_oe}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
        total++; if ({rsp_valid, rsp_bit, rsp_arb_lost, bus_busy} !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b want=0000", {rsp_valid, rsp_bit, rsp_arb_lost, bus_busy}); end
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe_post got=%b want=00", {scl_oe, sda_oe}); end
    endtask

    task automatic test_start_write();
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 17) begin bad++; $display("FAIL start_lat got=%0d want=17", lat); end
        total++; if ({rb, ra} !== 2'b00) begin bad++; $display("FAIL start_rsp got=%b want=00", {rb, ra}); end
        total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", bus_busy); end
        total++; if ({scl_oe, sda_oe} !== 2'b11) begin bad++; $display("FAIL start_oe got=%b want=11", {scl_oe, sda_oe}); end
        issue(OP_WRITE, 1'b1, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 19) begin bad++; $display("FAIL write1_lat got=%0d want=19", lat); end
        total++; if ({rb, ra} !== 2'b10) begin bad++; $display("FAIL write1_rsp got=%b want=10", {rb, ra}); end
    endtask

    task automatic test_read_stop();
        comp_sda = 1'b1;
        issue(OP_READ, 1'b0, 16'd3, lat, rb, ra, rr);
        comp_sda = 1'b0;
        total++; if (lat !== 19) begin bad++; $display("FAIL read_lat got=%0d want=19", lat); end
        total++; if ({rb, ra} !== 2'b00) begin bad++; $display("FAIL read_rsp got=%b want=00", {rb, ra}); end
        issue(OP_STOP, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 19) begin bad++; $display("FAIL stop_lat got=%0d want=19", lat); end
        total++; if ({rb, ra} !== 2'b00) begin bad++; $display("FAIL stop_rsp got=%b want=00", {rb, ra}); end
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", bus_busy); end
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL stop_oe got=%b want=00", {scl_oe, sda_oe}); end
    endtask

    task automatic test_stretch();
        int seen, sda_bad;
        seen = 0; sda_bad = 0;
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 17) begin bad++; $display("FAIL stretch_start_lat got=%0d want=17", lat); end
        ext_scl = 1'b1;
        fork
            issue(OP_WRITE, 1'b0, 16'd3, lat, rb, ra, rr);
            begin
                for (int i = 0; i < 200 && seen == 0; i++) begin
                    @(posedge clk); #1;
                    if (!scl_oe) seen = 1;
                end
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk); #1;
                    if (sda_oe !== 1'b1) sda_bad++;
                end
                ext_scl = 1'b0;
            end
        join
        total++; if (seen !== 1) begin bad++; $display("FAIL stretch_release got=%0d want=1", seen); end
        total++; if (lat !== 69) begin bad++; $display("FAIL stretch_lat got=%0d want=69", lat); end
        total++; if (sda_bad !== 0) begin bad++; $display("FAIL stretch_sda_stable got=%0d want=0", sda_bad); end
        total++; if ({rb, ra} !== 2'b00) begin bad++; $display("FAIL stretch_rsp got=%b want=00", {rb, ra}); end
    endtask

    task automatic test_arb_loss();
        comp_sda = 1'b1;
        issue(OP_WRITE, 1'b1, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 15) begin bad++; $display("FAIL arb_lat got=%0d want=15", lat); end
        total++; if ({rb, ra} !== 2'b01) begin bad++; $display("FAIL arb_rsp got=%b want=01", {rb, ra}); end
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL arb_oe got=%b want=00", {scl_oe, sda_oe}); end
        total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL arb_busy got=%b want=1", bus_busy); end
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 1) begin bad++; $display("FAIL busy_start_lat got=%0d want=1", lat); end
        total++; if ({rb, ra} !== 2'b01) begin bad++; $display("FAIL busy_start_rsp got=%b want=01", {rb, ra}); end
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL busy_start_oe got=%b want=00", {scl_oe, sda_oe}); end
        comp_sda = 1'b0;
        repeat (5) @(posedge clk); #1;
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL foreign_stop_busy got=%b want=0", bus_busy); end
    endtask

    task automatic test_illegal();
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if ({lat == 17, ra} !== 2'b10) begin bad++; $display("FAIL ill_start got lat=%0d arb=%b want lat=17 arb=0", lat, ra); end
        issue(3'd6, 1'b1, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 1) begin bad++; $display("FAIL ill6_lat got=%0d want=1", lat); end
        total++; if ({rb, ra} !== 2'b00) begin bad++; $display("FAIL ill6_rsp got=%b want=00", {rb, ra}); end
        total++; if ({scl_oe, sda_oe} !== 2'b11) begin bad++; $display("FAIL ill6_oe got=%b want=11", {scl_oe, sda_oe}); end
        issue(3'd5, 1'b1, 16'd3, lat, rb, ra, rr);
        total++; if ({lat == 1, rb, ra, scl_oe, sda_oe} !== 5'b10011) begin bad++; $display("FAIL ill5 got lat=%0d rsp=%b oe=%b want lat=1 rsp=00 oe=11", lat, {rb, ra}, {scl_oe, sda_oe}); end
        issue(OP_STOP, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if ({lat == 19, bus_busy} !== 2'b10) begin bad++; $display("FAIL ill_stop got lat=%0d busy=%b want lat=19 busy=0", lat, bus_busy); end
    endtask

    task automatic test_back_to_back();
        issue(OP_START, 1'b0, 16'd0, lat, rb, ra, rr);
        total++; if (lat !== 5) begin bad++; $display("FAIL b2b_start_lat got=%0d want=5", lat); end
        total++; if (rr !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", rr); end
        issue(OP_WRITE, 1'b1, 16'd0, lat, rb, ra, rr);
        total++; if ({lat == 7, rb, ra} !== 3'b110) begin bad++; $display("FAIL b2b_write got lat=%0d rsp=%b want lat=7 rsp=10", lat, {rb, ra}); end
        issue(OP_READ, 1'b0, 16'd0, lat, rb, ra, rr);
        total++; if ({lat == 7, rb, ra} !== 3'b110) begin bad++; $display("FAIL b2b_read got lat=%0d rsp=%b want lat=7 rsp=10", lat, {rb, ra}); end
        issue(OP_RESTART, 1'b0, 16'd0, lat, rb, ra, rr);
        total++; if ({lat == 7, rb, ra, bus_busy} !== 4'b1001) begin bad++; $display("FAIL b2b_restart got lat=%0d rsp=%b busy=%b want lat=7 rsp=00 busy=1", lat, {rb, ra}, bus_busy); end
        issue(OP_STOP, 1'b0, 16'd0, lat, rb, ra, rr);
        total++; if (lat !== 7) begin bad++; $display("FAIL b2b_stop_lat got=%0d want=7", lat); end
        repeat (2) @(posedge clk); #1;
        total++; if ({bus_busy, scl_oe, sda_oe} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b want=000", {bus_busy, scl_oe, sda_oe}); end
    endtask

    task automatic test_reset_mid();
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if (lat !== 17) begin bad++; $display("FAIL rmid_start_lat got=%0d want=17", lat); end
        cfg_div = 16'd3; cmd_op = OP_WRITE; cmd_bit = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (11) @(posedge clk); #1;
        total++; if ({scl_oe, sda_oe} !== 2'b01) begin bad++; $display("FAIL rmid_q2_oe got=%b want=01", {scl_oe, sda_oe}); end
        rst = 1'b1;
        #1;
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL rmid_oe got=%b want=00", {scl_oe, sda_oe}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if ({cmd_ready, bus_busy, rsp_valid} !== 3'b100) begin bad++; $display("FAIL rmid_post got=%b want=100", {cmd_ready, bus_busy, rsp_valid}); end
        issue(OP_START, 1'b0, 16'd3, lat, rb, ra, rr);
        total++; if ({lat == 17, ra, bus_busy} !== 3'b101) begin bad++; $display("FAIL rmid_restart got lat=%0d arb=%b busy=%b want lat=17 arb=0 busy=1", lat, ra, bus_busy); end
    endtask

    initial begin
        test_reset();
        test_start_write();
        test_read_stop();
        test_stretch();
        test_arb_loss();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
